twos_ser_feeder: RTL and testbench
==================================

// Module: twos_ser_feeder
// PURPOSE
//  - Upstream stage for the serial two's-complement converter.
//  - Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per t_clk.
//  - Raises ser_first on bit 0 so the converter clears its "seen-a-one" history at each frame start.
//  - Counts completed frames for debug.
// PARAMETERS
//  - WIDTH  8  bits per word; legal range WIDTH >= 2.
// PORTS
//  - t_clk      in   1      single clock; rising edge.
//  - r_n        in   1      reset; asynchronous, active-low.
//  - in_valid   in   1      in_data is offered.
//  - in_ready   out  1      feeder can take a word this cycle.
//  - in_data    in   WIDTH  word to serialise.
//  - ser_bit    out  1      current serial bit; drives converter input i.
//  - ser_valid  out  1      ser_bit is meaningful this cycle.
//  - ser_first  out  1      bit 0 of a frame; drives converter input r.
//  - ser_last   out  1      bit WIDTH-1 of a frame.
//  - frame_cnt  out  8      completed frames; modulo 256.
// BEHAVIOUR
//  - Reset (r_n=0, asynchronous):
//    - state=S_IDLE; shreg, cnt and frame_cnt = 0; live=0.
//    - Outputs: ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, in_ready=0, frame_cnt=0.
//  - live: flop that goes to 1 on the first t_clk edge after r_n rises. in_ready is 0 until live=1.
//  - Output timing: all outputs decode registered state only; no combinational path from in_valid or in_data.
//  - Accept: in_valid & in_ready at edge N loads shreg=in_data, clears cnt, enters S_SHIFT.
//  - Latency: bit 0 appears in cycle N+1; bit WIDTH-1 appears in cycle N+WIDTH.
//  - S_IDLE:
//    - in_ready = live.
//    - ser_valid, ser_first and ser_last are 0; ser_bit = 0.
//  - S_SHIFT:
//    - ser_valid=1, ser_bit=shreg[0].
//    - ser_first = (cnt==0); ser_last = (cnt==WIDTH-1).
//    - Each edge: shreg >>= 1 (zero fill), cnt++.
//  - Transition S_SHIFT -> S_IDLE: on the edge where cnt==WIDTH-1. frame_cnt increments on the same edge.
//  - in_data changing while not accepted: ignored. Words are never dropped or duplicated.
//  - Held-off word: in_valid asserted during S_SHIFT with in_ready=0 is held by the source and taken later.
//  - Reset mid-frame: the frame is aborted and outputs return to reset values immediately.
//    - frame_cnt is not incremented for the aborted frame.
//    - The next frame starts with ser_first=1.
//  - frame_cnt wraps from 255 to 0.
// CONFIGURATION
//  - Macro: TWOS_SER_SKID_EN.
//  - Defined (back-to-back frames):
//    - in_ready is also 1 in S_SHIFT while cnt==WIDTH-1.
//    - A word accepted on that edge reloads shreg, clears cnt and stays in S_SHIFT.
//    - Frames then run contiguously; ser_first follows ser_last with no gap.
//  - Undefined: in_ready=1 only in S_IDLE, so there is at least one idle cycle (ser_valid=0) between frames.
// STRUCTURE
//  - Package twos_ser_pkg:
//    - typedef enum {S_IDLE, S_SHIFT} twos_ser_state_t.
//    - localparam FRAME_CNT_W = 8.
//    - function cnt_w(WIDTH) = $clog2(WIDTH).
//  - Sub-module twos_ser_cnt: modulo-WIDTH counter with clear, increment and terminal flag (cnt==WIDTH-1).
//  - Shift register and FSM stay in this module.
// TESTING
//  - Reset: r_n=0 -> all outputs 0, in_ready=0. After release, in_ready=0 for 1 cycle, then 1.
//  - Frame: WIDTH=8, in_data=8'h2C accepted at N.
//    - ser_bit in N+1..N+8 = 0,0,1,1,0,1,0,0.
//    - ser_first only at N+1, ser_last only at N+8.
//    - Converter output collected = 8'hD4.
//  - Back-to-back: in_valid held with 8'h01 then 8'h80.
//    - Macro off: 1 idle cycle between frames.
//    - Macro on: 16 contiguous ser_valid cycles.
//    - Both: frame_cnt=2.
//  - Stall: in_valid=1 with 8'h55 during S_SHIFT (macro off) -> in_ready=0, word accepted at first S_IDLE cycle.
//  - Abort: 8'hFF, r_n=0 during bit 3 -> outputs 0 asynchronously, frame_cnt unchanged.
//    - Next word 8'h03 -> ser_bit sequence 1,1,0,0,0,0,0,0.
//  - Wrap: 256 frames -> frame_cnt returns to 0.

Source files
------------

// File: rtl/twos_ser_pkg.sv
// twos_ser_pkg
//   Shared types and constants for the serial two's-complement feeder.
//   - twos_ser_state_t : feeder FSM states
//   - FRAME_CNT_W      : width of the completed-frame debug counter
//   - cnt_w()          : bit-position counter width for a given word width
package twos_ser_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } twos_ser_state_t;

    localparam int FRAME_CNT_W = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/twos_ser_cnt.sv
// twos_ser_cnt
//   Modulo-WIDTH bit-position counter for the serial feeder.
//   Ports:
//     clk   in   clock, rising edge
//     rst_n in   asynchronous active-low reset
//     clr   in   force count to 0 (wins over inc)
//     inc   in   advance count, wrapping WIDTH-1 -> 0
//     cnt   out  current count
//     term  out  cnt == WIDTH-1
module twos_ser_cnt
    import twos_ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [cnt_w(WIDTH)-1:0]   cnt,
    output logic                      term
);

    localparam int CW = cnt_w(WIDTH);

    assign term = (cnt == CW'(WIDTH - 1));

    // Clear has priority so a word accepted on the terminal edge restarts at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (term) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/twos_ser_feeder.sv
// twos_ser_feeder
//   Upstream stage for the serial two's-complement converter. Takes a
//   parallel word over valid/ready and shifts it out LSB-first, one bit per
//   clock, flagging the first and last bit of each frame. Counts completed
//   frames (modulo 256) for debug.
//   Ports:
//     t_clk      in   clock, rising edge
//     r_n        in   asynchronous active-low reset
//     in_valid   in   in_data is offered
//     in_ready   out  feeder takes a word this cycle
//     in_data    in   word to serialise
//     ser_bit    out  current serial bit (converter input i)
//     ser_valid  out  ser_bit meaningful
//     ser_first  out  bit 0 of a frame (converter input r)
//     ser_last   out  bit WIDTH-1 of a frame
//     frame_cnt  out  completed frames, modulo 256
//   Configuration:
//     TWOS_SER_SKID_EN  when defined, a new word may be taken on the last
//                       bit of a frame so frames run back-to-back.
module twos_ser_feeder
    import twos_ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   t_clk,
    input  logic                   r_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   ser_bit,
    output logic                   ser_valid,
    output logic                   ser_first,
    output logic                   ser_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int CW = cnt_w(WIDTH);

    twos_ser_state_t  state_q;
    twos_ser_state_t  state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             cnt_term;
    logic             live;
    logic             shifting;
    logic             accept;

    assign shifting = (state_q == S_SHIFT);
    assign accept   = in_valid & in_ready;

    twos_ser_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (t_clk),
        .rst_n (r_n),
        .clr   (accept),
        .inc   (shifting),
        .cnt   (cnt),
        .term  (cnt_term)
    );

    // Holds off in_ready for one cycle after reset release.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready decodes registered state only, keeping in_valid off any output path.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = live;
`ifdef TWOS_SER_SKID_EN
            S_SHIFT: in_ready = cnt_term;
`else
            S_SHIFT: in_ready = 1'b0;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // Next state and serial outputs.
    always_comb begin
        state_d   = state_q;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = shreg[0];
                ser_first = (cnt == '0);
                ser_last  = cnt_term;
                if (cnt_term) begin
                    state_d = accept ? S_SHIFT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= in_data;
        end else if (shifting) begin
            shreg <= shreg >> 1;
        end
    end

    // A frame completes on the edge that leaves its last bit.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            frame_cnt <= '0;
        end else if (shifting && cnt_term) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_twos_ser_feeder.sv
// tb_twos_ser_feeder
//   Self-checking bench for twos_ser_feeder (WIDTH=8). A transaction-level
//   model predicts every output from the accept edge and the word accepted;
//   table vectors and hand-written sequences cover the directed cases.
module tb_twos_ser_feeder;

    localparam int WIDTH = 8;
`ifdef TWOS_SER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       t_clk;
    logic       r_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_first;
    logic       ser_last;
    logic [7:0] frame_cnt;

    twos_ser_feeder #(
        .WIDTH (WIDTH)
    ) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .frame_cnt (frame_cnt)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    // Model state: edge index of the most recent accept and the word taken.
    int         edge_no     = 0;
    int         acc_edge    = -100;
    logic [7:0] acc_word    = '0;
    int         frames      = 0;
    bit         model_live  = 1'b0;
    bit         last_accept = 1'b0;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] vlog[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] exp;
    } vec_t;

    function automatic bit exp_ready();
        return model_live && (edge_no + 1 >= acc_edge + WIDTH + (SKID ? 0 : 1));
    endfunction

    task automatic check_output(input string name);
        logic [12:0] exp;
        logic [12:0] act;
        int          j;
        bit          active;
        logic        eb;
        j      = edge_no - acc_edge;
        active = (j >= 0) && (j < WIDTH);
        eb     = active ? acc_word[j[2:0]] : 1'b0;
        exp = {exp_ready(), active, eb, active && (j == 0), active && (j == WIDTH - 1), 8'(frames)};
        act = {in_ready, ser_valid, ser_bit, ser_first, ser_last, frame_cnt};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s edge %0d: rdy/vld/bit/first/last/cnt got %b required %b",
                     name, edge_no, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input string name);
        bit acc;
        in_valid = v;
        in_data  = d;
        acc      = v && exp_ready();
        @(posedge t_clk);
        edge_no++;
        #1;
        last_accept = acc;
        if (r_n) begin
            if (edge_no == acc_edge + WIDTH) frames++;
            if (acc) begin
                acc_edge = edge_no;
                acc_word = d;
            end
            model_live = 1'b1;
        end
        vlog.push_back({ser_valid, ser_first});
        check_output(name);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        r_n      = 1'b0;
        #1;
        model_live = 1'b0;
        acc_edge   = -100;
        frames     = 0;
        check_output("reset_async");
        repeat (2) begin
            @(posedge t_clk);
            edge_no++;
            #1;
            check_output("reset_hold");
        end
        #2 r_n = 1'b1;
        #1;
        check_output("reset_release");
    endtask

    task automatic wait_accept(input logic [7:0] d, input string name);
        int n;
        n = 0;
        do begin
            apply_stimulus(1'b1, d, name);
            n++;
        end while (!last_accept && n < 30);
        in_valid = 1'b0;
        if (!last_accept) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: got no accept, required accept within 30 cycles", name);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       tbl[9];
        logic [7:0] conv;
        logic [7:0] cap;
        bit         seen;
        int         k;
        int         first_v;
        int         last_v;
        int         ones;
        int         zeros;
        int         firsts[$];
        int         guard;

        r_n      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        tbl[0] = '{1'b1, 8'h2C, 4'b1010};
        tbl[1] = '{1'b0, 8'hFF, 4'b1000};
        tbl[2] = '{1'b0, 8'h5A, 4'b1100};
        tbl[3] = '{1'b0, 8'h00, 4'b1100};
        tbl[4] = '{1'b0, 8'h33, 4'b1000};
        tbl[5] = '{1'b0, 8'h00, 4'b1100};
        tbl[6] = '{1'b0, 8'h00, 4'b1000};
        tbl[7] = '{1'b0, 8'h00, 4'b1001};
        tbl[8] = '{1'b0, 8'h00, 4'b0000};

        $display("[TB] reset and single frame 8'h2C");
        do_reset();
        apply_stimulus(1'b0, 8'h00, "live_up");
        conv = '0;
        seen = 1'b0;
        k    = 0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(tbl[i].v, tbl[i].d, "frame_2C");
            vectors++;
            if ({ser_valid, ser_bit, ser_first, ser_last} !== tbl[i].exp) begin
                miscompares++;
                $display("[TB] FAIL table_2C[%0d]: vld/bit/first/last got %b required %b",
                         i, {ser_valid, ser_bit, ser_first, ser_last}, tbl[i].exp);
            end
            if (ser_valid && k < 8) begin
                if (ser_first) seen = 1'b0;
                conv[k[2:0]] = ser_bit ^ seen;
                seen = seen | ser_bit;
                k++;
            end
        end
        expect_int("converter_2C", int'(conv), 8'hD4);

        $display("[TB] back-to-back 8'h01 then 8'h80");
        do_reset();
        vlog.delete();
        wait_accept(8'h01, "b2b_first");
        wait_accept(8'h80, "b2b_second");
        repeat (12) apply_stimulus(1'b0, 8'h00, "b2b_drain");
        first_v = -1;
        last_v  = -1;
        for (int i = 0; i < vlog.size(); i++) begin
            if (vlog[i][1]) begin
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        ones  = 0;
        zeros = 0;
        if (first_v >= 0) begin
            for (int i = first_v; i <= last_v; i++) begin
                if (vlog[i][1]) ones++;
                else zeros++;
            end
        end
        expect_int("b2b_valid_cycles", ones, 16);
        expect_int("b2b_idle_gap", zeros, SKID ? 0 : 1);
        expect_int("b2b_frame_cnt", int'(frame_cnt), 2);

        $display("[TB] held-off word 8'h55");
        do_reset();
        apply_stimulus(1'b0, 8'h00, "live_up");
        vlog.delete();
        wait_accept(8'hA0, "stall_first");
        wait_accept(8'h55, "stall_held");
        repeat (10) apply_stimulus(1'b0, 8'h00, "stall_drain");
        firsts.delete();
        for (int i = 0; i < vlog.size(); i++) begin
            if (vlog[i][0]) firsts.push_back(i);
        end
        expect_int("stall_frames", firsts.size(), 2);
        if (firsts.size() == 2) begin
            expect_int("stall_first_spacing", firsts[1] - firsts[0], WIDTH + (SKID ? 0 : 1));
        end

        $display("[TB] abort during bit 3");
        do_reset();
        apply_stimulus(1'b0, 8'h00, "live_up");
        wait_accept(8'hFF, "abort_word");
        repeat (3) apply_stimulus(1'b0, 8'h00, "abort_bits");
        do_reset();
        expect_int("abort_frame_cnt", int'(frame_cnt), 0);
        apply_stimulus(1'b0, 8'h00, "live_up");
        wait_accept(8'h03, "after_abort");
        expect_int("after_abort_first", int'(ser_first), 1);
        cap    = '0;
        cap[0] = ser_bit;
        for (int i = 1; i < 8; i++) begin
            apply_stimulus(1'b0, 8'h00, "after_abort_bits");
            cap[i] = ser_bit;
        end
        expect_int("after_abort_bits", int'(cap), 8'h03);

        $display("[TB] randomized traffic until frame_cnt wraps");
        do_reset();
        guard = 0;
        while (frames < 256 && guard < 8000) begin
            apply_stimulus(($urandom_range(0, 3) != 0), 8'($urandom), "random");
            guard++;
        end
        expect_int("wrap_frames_done", frames, 256);
        expect_int("wrap_frame_cnt", int'(frame_cnt), 0);
        repeat (10) apply_stimulus(1'b0, 8'h00, "random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
